scratchpad_mem_arbiter: RTL and testbench
=========================================

// Module: scratchpad_mem_arbiter
// PURPOSE
//  Shares one host memory streaming port (read/write enable, ready, finish strobes) among NREQ
//  scratchpad reload controllers, one whole burst at a time. Sits between the per-kernel scratchpad
//  wrappers and the top-level host interface. Grants rotate round-robin. A grant is held until the
//  owner drops its enable, so host-side burst boundaries are never interleaved.
// PARAMETERS
//  NREQ      2   number of requesters, 2..4
//  IDX_W     2   width of grant index, >= clog2(NREQ)
// PORTS
//  clk               in   1          sole clock, all state on posedge
//  reset             in   1          synchronous, active-high
//  req_read_enable   in   NREQ       per-requester read burst request
//  req_write_enable  in   NREQ       per-requester write burst request
//  req_read_addr     in   64*NREQ    read byte address, requester i at [64*i+:64]
//  req_write_addr    in   64*NREQ    write byte address
//  req_read_size     in   64*NREQ    read beat stride in bytes
//  req_write_size    in   64*NREQ    write beat stride in bytes
//  req_finish_read   in   NREQ       per-beat read acknowledge from requester
//  req_finish_write  in   NREQ       per-beat write acknowledge from requester
//  req_write_data    in   32*NREQ    write beat data
//  req_read_ready    out  NREQ       host read_ready routed to the owner only
//  req_write_ready   out  NREQ       host write_ready routed to the owner only
//  req_read_data     out  32         host read_data, broadcast (qualify with req_read_ready)
//  read_ready        in   64         host read beat valid, true when ==1
//  write_ready       in   64         host write beat accepted, true when ==1
//  read_data         in   32         host read beat data
//  read_enable, write_enable, finish_read, finish_write  out 1 each: owner's signals, else 0
//  read_addr, write_addr, read_size_output, write_size   out 64 each: owner's values, else 0
//  write_data        out  32         owner's write data, else 0
//  grant_valid       out  1          1 in GRANT_RD/GRANT_WR
//  grant_idx         out  IDX_W      current/last owner
// BEHAVIOUR
//  Reset: state=IDLE; rr_ptr=NREQ-1, so requester 0 wins first; all outputs 0.
//   Reset mid-burst drops all host outputs to 0 on the next edge. No drain.
//  FSM: IDLE -> GRANT_WR | GRANT_RD -> RELEASE -> IDLE.
//  IDLE:
//   - Candidates are requesters with read or write enable high.
//   - Pick the first candidate scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ.
//   - Register grant_idx and set rr_ptr to the winner. Takes 1 cycle.
//   - If the winner's write enable is high, go to GRANT_WR; else GRANT_RD. Write wins because
//     flush precedes refill.
//  GRANT_RD:
//   - Combinational mux forwards the owner's read-side signals to the host.
//   - Host read_ready==1 drives req_read_ready[owner] only.
//   - Exit to RELEASE on the first cycle the owner's req_read_enable is 0.
//  GRANT_WR:
//   - Symmetric on the write side.
//   - Exit when the owner's req_write_enable is 0.
//   - If the owner's read enable is high at exit, it re-competes in IDLE like any other requester.
//  RELEASE:
//   - One bubble cycle with all host enables 0, so the host sees an enable edge between bursts.
//   - Then go to IDLE.
//  Non-owner requesters always see ready=0. Host ready outside GRANT states is ignored.
//  Simultaneous requests: strict round-robin, no starvation. Worst-case wait is
//  (NREQ-1) bursts + 3*(NREQ-1) cycles.
//  An owner asserting both enables in GRANT_RD does not switch direction mid-grant.
//  Requester widths are fixed, no arithmetic beyond the modulo-NREQ pointer increment.
//  Address/size values pass through unchanged.
// CONFIGURATION
//  ARB_STATS_EN defined:
//   - Adds output grant_count[32*NREQ]: per-requester count of grants, +1 on each IDLE->GRANT edge,
//     wraps at 2^32.
//   - Adds output wait_cycles[32*NREQ]: +1 per cycle a requester has an enable high while not owner.
//   - Both counters clear on reset.
//  ARB_STATS_EN undefined: both ports and their counters are absent. Grant behaviour is identical.
// TESTING
//  T1 single: req0 read burst of 2 beats at 0x1000 stride 4
//     -> host read_addr=0x1000, req_read_ready[0] pulses twice, req1 ready stays 0, RELEASE bubble seen.
//  T2 contention: req0 and req1 both raise read_enable in the same cycle after reset
//     -> req0 granted first; after req0 drops, 1-cycle bubble, then grant_idx=1.
//  T3 fairness: both requesters re-request continuously for 6 bursts -> grants alternate 0,1,0,1,0,1.
//  T4 write priority: req1 raises write_enable and read_enable together
//     -> GRANT_WR first with write_data forwarded, then a separate GRANT_RD.
//  T5 reset mid-burst: assert reset during beat 1 of a req0 write
//     -> next cycle write_enable=0, grant_valid=0; after release, req1 alone is granted.
//  T6 (ARB_STATS_EN): run T3 -> grant_count = 3 and 3; wait_cycles > 0 for each.

Source files
------------

// File: rtl/scratchpad_mem_arbiter_if.sv
// Bus bundle between NREQ scratchpad reload controllers, the arbiter and the host streaming port.
// master = arbiter view, slave = requester/host environment view.
interface scratchpad_mem_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 2
);
  logic [NREQ-1:0]      req_read_enable;
  logic [NREQ-1:0]      req_write_enable;
  logic [64*NREQ-1:0]   req_read_addr;
  logic [64*NREQ-1:0]   req_write_addr;
  logic [64*NREQ-1:0]   req_read_size;
  logic [64*NREQ-1:0]   req_write_size;
  logic [NREQ-1:0]      req_finish_read;
  logic [NREQ-1:0]      req_finish_write;
  logic [32*NREQ-1:0]   req_write_data;
  logic [NREQ-1:0]      req_read_ready;
  logic [NREQ-1:0]      req_write_ready;
  logic [31:0]          req_read_data;
  logic [63:0]          read_ready;
  logic [63:0]          write_ready;
  logic [31:0]          read_data;
  logic                 read_enable;
  logic                 write_enable;
  logic                 finish_read;
  logic                 finish_write;
  logic [63:0]          read_addr;
  logic [63:0]          write_addr;
  logic [63:0]          read_size_output;
  logic [63:0]          write_size;
  logic [31:0]          write_data;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;

  modport master (
    input  req_read_enable, req_write_enable, req_read_addr, req_write_addr,
           req_read_size, req_write_size, req_finish_read, req_finish_write,
           req_write_data, read_ready, write_ready, read_data,
    output req_read_ready, req_write_ready, req_read_data, read_enable, write_enable,
           finish_read, finish_write, read_addr, write_addr, read_size_output,
           write_size, write_data, grant_valid, grant_idx
  );

  modport slave (
    output req_read_enable, req_write_enable, req_read_addr, req_write_addr,
           req_read_size, req_write_size, req_finish_read, req_finish_write,
           req_write_data, read_ready, write_ready, read_data,
    input  req_read_ready, req_write_ready, req_read_data, read_enable, write_enable,
           finish_read, finish_write, read_addr, write_addr, read_size_output,
           write_size, write_data, grant_valid, grant_idx
  );
endinterface

// File: rtl/scratchpad_mem_arbiter.sv
// Round-robin, whole-burst arbiter sharing one host streaming port among NREQ reload controllers.
// Define ARB_STATS_EN to add per-requester grant_count / wait_cycles counters.
module scratchpad_mem_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  scratchpad_mem_arbiter_if.master  bus
`ifdef ARB_STATS_EN
  ,
  output logic [32*NREQ-1:0]        grant_count,
  output logic [32*NREQ-1:0]        wait_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, GRANT_RD, GRANT_WR, RELEASE} state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] grant_idx_reg;
  logic             grant_valid_reg;

  logic [NREQ-1:0]  cand;
  logic             pick_found;
  logic             pick_wr;
  logic [IDX_W-1:0] pick_idx;

  logic [NREQ-1:0]  own_sel;
  logic             own_rd_en, own_wr_en, own_fin_rd, own_fin_wr;
  logic [63:0]      own_raddr, own_waddr, own_rsize, own_wsize;
  logic [31:0]      own_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = bus.req_read_enable[gi] | bus.req_write_enable[gi];
    end
  endgenerate

  // First candidate after the last winner, modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_wr    = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pick_found && cand[i] && (i == (int'(rr_ptr_reg) + k) % NREQ)) begin
          pick_found = 1'b1;
          pick_idx   = IDX_W'(i);
          pick_wr    = bus.req_write_enable[i];
        end
      end
    end
  end

  always_comb begin
    own_sel    = '0;
    own_rd_en  = 1'b0;
    own_wr_en  = 1'b0;
    own_fin_rd = 1'b0;
    own_fin_wr = 1'b0;
    own_raddr  = '0;
    own_waddr  = '0;
    own_rsize  = '0;
    own_wsize  = '0;
    own_wdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx_reg == IDX_W'(i)) begin
        own_sel[i] = 1'b1;
        own_rd_en  = bus.req_read_enable[i];
        own_wr_en  = bus.req_write_enable[i];
        own_fin_rd = bus.req_finish_read[i];
        own_fin_wr = bus.req_finish_write[i];
        own_raddr  = bus.req_read_addr[64*i +: 64];
        own_waddr  = bus.req_write_addr[64*i +: 64];
        own_rsize  = bus.req_read_size[64*i +: 64];
        own_wsize  = bus.req_write_size[64*i +: 64];
        own_wdata  = bus.req_write_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= IDX_W'(NREQ - 1);
      grant_idx_reg   <= '0;
      grant_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_idx_reg   <= pick_idx;
            rr_ptr_reg      <= pick_idx;
            grant_valid_reg <= 1'b1;
            // Write first: a flush must land before the refill that follows it.
            state_reg       <= pick_wr ? GRANT_WR : GRANT_RD;
          end
        end
        GRANT_RD: begin
          if (!own_rd_en) begin
            state_reg       <= RELEASE;
            grant_valid_reg <= 1'b0;
          end
        end
        GRANT_WR: begin
          if (!own_wr_en) begin
            state_reg       <= RELEASE;
            grant_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic in_rd, in_wr;
  assign in_rd = (state_reg == GRANT_RD);
  assign in_wr = (state_reg == GRANT_WR);

  assign bus.read_enable      = in_rd & own_rd_en;
  assign bus.finish_read      = in_rd & own_fin_rd;
  assign bus.read_addr        = in_rd ? own_raddr : 64'd0;
  assign bus.read_size_output = in_rd ? own_rsize : 64'd0;
  assign bus.write_enable     = in_wr & own_wr_en;
  assign bus.finish_write     = in_wr & own_fin_wr;
  assign bus.write_addr       = in_wr ? own_waddr : 64'd0;
  assign bus.write_size       = in_wr ? own_wsize : 64'd0;
  assign bus.write_data       = in_wr ? own_wdata : 32'd0;
  assign bus.req_read_ready   = (in_rd && bus.read_ready == 64'd1) ? own_sel : '0;
  assign bus.req_write_ready  = (in_wr && bus.write_ready == 64'd1) ? own_sel : '0;
  assign bus.req_read_data    = bus.read_data;
  assign bus.grant_valid      = grant_valid_reg;
  assign bus.grant_idx        = grant_idx_reg;

`ifdef ARB_STATS_EN
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_stats
      logic [31:0] grant_cnt_reg;
      logic [31:0] wait_cnt_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          grant_cnt_reg <= '0;
          wait_cnt_reg  <= '0;
        end else begin
          if (state_reg == IDLE && pick_found && pick_idx == IDX_W'(gi))
            grant_cnt_reg <= grant_cnt_reg + 32'd1;
          if (cand[gi] && !(grant_valid_reg && grant_idx_reg == IDX_W'(gi)))
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
        end
      end
      assign grant_count[32*gi +: 32] = grant_cnt_reg;
      assign wait_cycles[32*gi +: 32] = wait_cnt_reg;
    end
  endgenerate
`endif
endmodule

// File: tb/tb_scratchpad_mem_arbiter.sv
// Self-checking bench for scratchpad_mem_arbiter: vector table, hand-written corner sequences,
// and randomized traffic against a burst-level reference model.
module tb_scratchpad_mem_arbiter;
  localparam int NREQ  = 2;
  localparam int IDX_W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scratchpad_mem_arbiter_if #(.NREQ(NREQ), .IDX_W(IDX_W)) bus ();

`ifdef ARB_STATS_EN
  logic [32*NREQ-1:0] grant_count;
  logic [32*NREQ-1:0] wait_cycles;
`endif

  scratchpad_mem_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef ARB_STATS_EN
    ,
    .grant_count(grant_count),
    .wait_cycles(wait_cycles)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.req_read_enable  = '0;
    bus.req_write_enable = '0;
    bus.req_read_addr    = {64'h2000, 64'h1000};
    bus.req_read_size    = {64'd8, 64'd4};
    bus.req_write_addr   = '0;
    bus.req_write_size   = '0;
    bus.req_finish_read  = '0;
    bus.req_finish_write = '0;
    bus.req_write_data   = '0;
    bus.read_ready       = '0;
    bus.write_ready      = '0;
    bus.read_data        = '0;
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  rd;
    logic [63:0] rr;
    logic        gv;
    logic [1:0]  gi;
    logic        re;
    logic [1:0]  rrdy;
    logic [63:0] raddr;
    logic [63:0] rsize;
  } vec_t;
  vec_t vt[18];

  // Reference model state: burst owner (-1 when none), its direction, bubble pending, last winner.
  int   m_owner, m_last, m_gidx;
  logic m_wr, m_bubble;

  task automatic model_reset;
    m_owner = -1; m_wr = 1'b0; m_bubble = 1'b0; m_last = NREQ - 1; m_gidx = 0;
  endtask

  initial begin
    int grants[$];
    int held;
    logic prev_gv;
    logic [1:0] rd_next;

    // T1 single read burst, then T2 contention after reset.
    vt[0]  = '{1'b1, 2'b00, 64'd0, 1'b0, 2'd0, 1'b0, 2'b00, 64'h0,    64'd0};
    vt[1]  = '{1'b0, 2'b01, 64'd0, 1'b0, 2'd0, 1'b0, 2'b00, 64'h0,    64'd0};
    vt[2]  = '{1'b0, 2'b01, 64'd0, 1'b1, 2'd0, 1'b1, 2'b00, 64'h1000, 64'd4};
    vt[3]  = '{1'b0, 2'b01, 64'd1, 1'b1, 2'd0, 1'b1, 2'b01, 64'h1000, 64'd4};
    vt[4]  = '{1'b0, 2'b01, 64'd2, 1'b1, 2'd0, 1'b1, 2'b00, 64'h1000, 64'd4};
    vt[5]  = '{1'b0, 2'b01, 64'd1, 1'b1, 2'd0, 1'b1, 2'b01, 64'h1000, 64'd4};
    vt[6]  = '{1'b0, 2'b00, 64'd0, 1'b1, 2'd0, 1'b0, 2'b00, 64'h1000, 64'd4};
    vt[7]  = '{1'b0, 2'b00, 64'd1, 1'b0, 2'd0, 1'b0, 2'b00, 64'h0,    64'd0};
    vt[8]  = '{1'b0, 2'b00, 64'd0, 1'b0, 2'd0, 1'b0, 2'b00, 64'h0,    64'd0};
    vt[9]  = '{1'b1, 2'b11, 64'd0, 1'b0, 2'd0, 1'b0, 2'b00, 64'h0,    64'd0};
    vt[10] = '{1'b0, 2'b11, 64'd0, 1'b0, 2'd0, 1'b0, 2'b00, 64'h0,    64'd0};
    vt[11] = '{1'b0, 2'b11, 64'd1, 1'b1, 2'd0, 1'b1, 2'b01, 64'h1000, 64'd4};
    vt[12] = '{1'b0, 2'b10, 64'd0, 1'b1, 2'd0, 1'b0, 2'b00, 64'h1000, 64'd4};
    vt[13] = '{1'b0, 2'b10, 64'd0, 1'b0, 2'd0, 1'b0, 2'b00, 64'h0,    64'd0};
    vt[14] = '{1'b0, 2'b10, 64'd0, 1'b0, 2'd0, 1'b0, 2'b00, 64'h0,    64'd0};
    vt[15] = '{1'b0, 2'b10, 64'd1, 1'b1, 2'd1, 1'b1, 2'b10, 64'h2000, 64'd8};
    vt[16] = '{1'b0, 2'b00, 64'd0, 1'b1, 2'd1, 1'b0, 2'b00, 64'h2000, 64'd8};
    vt[17] = '{1'b0, 2'b00, 64'd0, 1'b0, 2'd1, 1'b0, 2'b00, 64'h0,    64'd0};

    reset = 1'b1;
    clear_inputs();
    for (int i = 0; i < 18; i++) begin
      reset                = vt[i].rst;
      bus.req_read_enable  = vt[i].rd;
      bus.read_ready       = vt[i].rr;
      @(negedge clk);
      chk($sformatf("tbl%0d_gv", i),    64'(bus.grant_valid),      64'(vt[i].gv));
      chk($sformatf("tbl%0d_gi", i),    64'(bus.grant_idx),        64'(vt[i].gi));
      chk($sformatf("tbl%0d_re", i),    64'(bus.read_enable),      64'(vt[i].re));
      chk($sformatf("tbl%0d_rrdy", i),  64'(bus.req_read_ready),   64'(vt[i].rrdy));
      chk($sformatf("tbl%0d_raddr", i), bus.read_addr,             vt[i].raddr);
      chk($sformatf("tbl%0d_rsize", i), bus.read_size_output,      vt[i].rsize);
      $display("tbl row %0d rd=%b gv=%0d gi=%0d re=%0d rrdy=%b", i, vt[i].rd,
               bus.grant_valid, bus.grant_idx, bus.read_enable, bus.req_read_ready);
      next_cycle();
    end

    // T4: req1 raises write and read together: write burst first, then a separate read burst.
    reset = 1'b1; clear_inputs(); next_cycle();
    reset = 1'b0;
    bus.req_write_enable = 2'b10;
    bus.req_read_enable  = 2'b10;
    bus.req_write_data   = {32'hCAFE_F00D, 32'h0};
    bus.req_write_addr   = {64'h3000, 64'h0};
    bus.req_write_size   = {64'd16, 64'd0};
    bus.read_data        = 32'h1234_5678;
    @(negedge clk);
    chk("t4_idle_gv", 64'(bus.grant_valid), 64'd0);
    next_cycle();
    bus.write_ready = 64'd1;
    @(negedge clk);
    chk("t4_wr_gv",    64'(bus.grant_valid),     64'd1);
    chk("t4_wr_gi",    64'(bus.grant_idx),       64'd1);
    chk("t4_wr_we",    64'(bus.write_enable),    64'd1);
    chk("t4_wr_re",    64'(bus.read_enable),     64'd0);
    chk("t4_wr_wdata", 64'(bus.write_data),      64'hCAFE_F00D);
    chk("t4_wr_waddr", bus.write_addr,           64'h3000);
    chk("t4_wr_wsize", bus.write_size,           64'd16);
    chk("t4_wr_wrdy",  64'(bus.req_write_ready), 64'b10);
    next_cycle();
    bus.req_write_enable = 2'b00;
    bus.write_ready      = 64'd0;
    @(negedge clk);
    chk("t4_wrend_we", 64'(bus.write_enable), 64'd0);
    chk("t4_wrend_gv", 64'(bus.grant_valid),  64'd1);
    next_cycle();
    @(negedge clk);
    chk("t4_release_gv", 64'(bus.grant_valid), 64'd0);
    chk("t4_release_re", 64'(bus.read_enable), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("t4_idle2_gv", 64'(bus.grant_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("t4_rd_gv",    64'(bus.grant_valid),   64'd1);
    chk("t4_rd_gi",    64'(bus.grant_idx),     64'd1);
    chk("t4_rd_re",    64'(bus.read_enable),   64'd1);
    chk("t4_rd_we",    64'(bus.write_enable),  64'd0);
    chk("t4_rd_raddr", bus.read_addr,          64'h2000);
    chk("t4_rd_rdata", 64'(bus.req_read_data), 64'h1234_5678);
    $display("t4 write-then-read sequence done");
    bus.req_read_enable = 2'b00;
    next_cycle(); next_cycle(); next_cycle();

    // T5: reset during beat 1 of a req0 write burst.
    reset = 1'b1; clear_inputs(); next_cycle();
    reset = 1'b0;
    bus.req_write_enable = 2'b01;
    bus.req_write_addr   = {64'h0, 64'h4000};
    next_cycle();
    @(negedge clk);
    chk("t5_wr_we", 64'(bus.write_enable), 64'd1);
    chk("t5_wr_gi", 64'(bus.grant_idx),    64'd0);
    next_cycle();
    bus.write_ready = 64'd1;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.write_ready      = 64'd0;
    bus.req_write_enable = 2'b00;
    bus.req_read_enable  = 2'b10;
    @(negedge clk);
    chk("t5_after_we",    64'(bus.write_enable), 64'd0);
    chk("t5_after_gv",    64'(bus.grant_valid),  64'd0);
    chk("t5_after_waddr", bus.write_addr,        64'd0);
    next_cycle();
    @(negedge clk);
    chk("t5_req1_gv", 64'(bus.grant_valid), 64'd1);
    chk("t5_req1_gi", 64'(bus.grant_idx),   64'd1);
    chk("t5_req1_re", 64'(bus.read_enable), 64'd1);
    $display("t5 reset mid-burst sequence done");
    bus.req_read_enable = 2'b00;
    next_cycle(); next_cycle(); next_cycle();

    // T3: both requesters re-request continuously; each holds its grant for two cycles.
    reset = 1'b1; clear_inputs(); next_cycle();
    reset = 1'b0;
    bus.req_read_enable = 2'b11;
    held = 0;
    prev_gv = 1'b0;
    for (int c = 0; c < 300 && grants.size() < 6; c++) begin
      @(negedge clk);
      if (bus.grant_valid && !prev_gv) begin
        grants.push_back(int'(bus.grant_idx));
        held = 0;
        $display("t3 grant #%0d to req %0d", grants.size(), bus.grant_idx);
      end
      prev_gv = bus.grant_valid;
      if (bus.grant_valid) held++;
      rd_next = 2'b11;
      if (bus.grant_valid && held >= 2) rd_next[bus.grant_idx[0]] = 1'b0;
      if (grants.size() >= 6) rd_next = 2'b00;
      next_cycle();
      bus.req_read_enable = rd_next;
    end
    bus.req_read_enable = 2'b00;
    chk("t3_grant_total", 64'(grants.size()), 64'd6);
    foreach (grants[i]) chk($sformatf("t3_grant%0d", i), 64'(grants[i]), 64'(i % 2));
    next_cycle(); next_cycle(); next_cycle(); next_cycle();

`ifdef ARB_STATS_EN
    chk("t6_grant_count0", 64'(grant_count[31:0]),  64'd3);
    chk("t6_grant_count1", 64'(grant_count[63:32]), 64'd3);
    chk("t6_wait0_nonzero", 64'(wait_cycles[31:0] != 32'd0),  64'd1);
    chk("t6_wait1_nonzero", 64'(wait_cycles[63:32] != 32'd0), 64'd1);
    $display("t6 stats grant=%0d,%0d wait=%0d,%0d", grant_count[31:0], grant_count[63:32],
             wait_cycles[31:0], wait_cycles[63:32]);
`endif

    // Randomized traffic against the burst-level model.
    reset = 1'b1; clear_inputs(); next_cycle();
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic        e_gv, e_re, e_we, e_fr, e_fw;
      logic [1:0]  e_rrdy, e_wrdy;
      logic [63:0] e_raddr, e_waddr, e_rsize;
      logic [31:0] e_wdata;
      logic [1:0]  rd, wr;
      logic        found;

      rd = bus.req_read_enable;
      wr = bus.req_write_enable;
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) rd[i] = ~rd[i];
        if ($urandom_range(0, 4) == 0) wr[i] = ~wr[i];
      end
      bus.req_read_enable  = rd;
      bus.req_write_enable = wr;
      bus.req_read_addr    = {$urandom, $urandom, $urandom, $urandom};
      bus.req_write_addr   = {$urandom, $urandom, $urandom, $urandom};
      bus.req_read_size    = {$urandom, $urandom, $urandom, $urandom};
      bus.req_write_data   = {$urandom, $urandom};
      bus.req_finish_read  = 2'($urandom);
      bus.req_finish_write = 2'($urandom);
      case ($urandom_range(0, 3))
        0: bus.read_ready = 64'd0;
        3: bus.read_ready = 64'h1_0000_0001;
        default: bus.read_ready = 64'd1;
      endcase
      bus.write_ready = ($urandom_range(0, 2) != 0) ? 64'd1 : 64'd2;
      reset = ($urandom_range(0, 63) == 0);

      e_gv = (m_owner >= 0);
      e_re = 0; e_we = 0; e_fr = 0; e_fw = 0; e_rrdy = 0; e_wrdy = 0;
      e_raddr = 0; e_waddr = 0; e_rsize = 0; e_wdata = 0;
      if (m_owner >= 0 && !m_wr) begin
        e_re    = rd[m_owner];
        e_fr    = bus.req_finish_read[m_owner];
        e_raddr = bus.req_read_addr[64*m_owner +: 64];
        e_rsize = bus.req_read_size[64*m_owner +: 64];
        if (bus.read_ready == 64'd1) e_rrdy[m_owner] = 1'b1;
      end
      if (m_owner >= 0 && m_wr) begin
        e_we    = wr[m_owner];
        e_fw    = bus.req_finish_write[m_owner];
        e_waddr = bus.req_write_addr[64*m_owner +: 64];
        e_wdata = bus.req_write_data[32*m_owner +: 32];
        if (bus.write_ready == 64'd1) e_wrdy[m_owner] = 1'b1;
      end

      @(negedge clk);
      chk($sformatf("rnd%0d_ctl", c),
          64'({bus.grant_valid, bus.grant_idx, bus.read_enable, bus.write_enable,
               bus.finish_read, bus.finish_write, bus.req_read_ready, bus.req_write_ready}),
          64'({e_gv, 2'(m_gidx), e_re, e_we, e_fr, e_fw, e_rrdy, e_wrdy}));
      chk($sformatf("rnd%0d_raddr", c), bus.read_addr,         e_raddr);
      chk($sformatf("rnd%0d_rsize", c), bus.read_size_output,  e_rsize);
      chk($sformatf("rnd%0d_waddr", c), bus.write_addr,        e_waddr);
      chk($sformatf("rnd%0d_wdata", c), 64'(bus.write_data),   64'(e_wdata));

      if (reset) begin
        model_reset();
        $display("rnd cyc=%0d reset", c);
      end else if (m_owner >= 0) begin
        if (m_wr ? !wr[m_owner] : !rd[m_owner]) begin
          m_owner  = -1;
          m_bubble = 1'b1;
        end
      end else if (m_bubble) begin
        m_bubble = 1'b0;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          int j;
          j = (m_last + k) % NREQ;
          if (!found && (rd[j] || wr[j])) begin
            found   = 1'b1;
            m_owner = j;
            m_wr    = wr[j];
            m_last  = j;
            m_gidx  = j;
            $display("rnd cyc=%0d grant req=%0d dir=%s", c, j, wr[j] ? "wr" : "rd");
          end
        end
      end
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
